// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage RISC-V pipeline.
// Runs a req/ack access to a variable-latency data memory, resolves the branch
// redirect and registers results into the MEM/WB boundary. While an access is
// outstanding it freezes the upstream stages through stall_o and feeds bubbles
// into MEM/WB. An access that is not acknowledged within TIMEOUT wait cycles is
// aborted, and a sticky err_o is raised.
//
// Handshake: dmem_req_o is a level request. Once it is raised, dmem_req_o,
// dmem_addr_o, dmem_wdata_o and dmem_we_o stay stable until the first cycle
// with dmem_ack_i=1. The memory completes the access in that cycle, and
// dmem_rdata_i is valid in the same cycle. The request drops on the next edge.
// dmem_ack_i is ignored whenever no request is outstanding.
module mem_access_stage #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] RS2data_i,
  input  logic        Zero_i,
  input  logic [31:0] pc_branch_i,
  input  logic        Branch_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        MemtoReg_i,
  input  logic        RegWrite_i,
  input  logic [4:0]  RDaddr_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        pc_src_o,
  output logic [31:0] pc_branch_o,
  output logic        err_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALUResult_o,
  output logic [4:0]  RDaddr_o,
  output logic        dbg_state_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
  // What the MEM/WB register captures on the coming edge
  typedef enum logic [1:0] {WB_BUBBLE, WB_PASS, WB_DONE, WB_ABORT} wb_sel_t;

  state_t           state_q, state_d;
  wb_sel_t          wb_sel;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_op;
  logic             cnt_last;
  logic             launch;

  // A load and a store flagged together are handled as a store
  assign mem_op      = start_i & (MemRead_i | MemWrite_i);
  assign cnt_last    = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign pc_src_o    = Branch_i & Zero_i & start_i;
  assign pc_branch_o = pc_branch_i;
  assign dbg_state_o = state_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: a flush always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (!start_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (mem_op) state_d = ST_WAIT;
        ST_WAIT: if (dmem_ack_i || cnt_last) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic: the stall and the MEM/WB capture select. Stall is held low during reset.
  always_comb begin
    stall_o = 1'b0;
    wb_sel  = WB_BUBBLE;
    launch  = 1'b0;
    if (start_i && rst_i) begin
      case (state_q)
        ST_IDLE: begin
          if (mem_op) begin
            stall_o = 1'b1;
            launch  = 1'b1;
          end else begin
            wb_sel = WB_PASS;
          end
        end
        ST_WAIT: begin
          if (dmem_ack_i)    wb_sel  = WB_DONE;
          else if (cnt_last) wb_sel  = WB_ABORT;
          else               stall_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Memory request side: the request is high exactly while in WAIT, and addr/data/we are latched at launch
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      cnt_q        <= '0;
      err_o        <= 1'b0;
    end else begin
      dmem_req_o <= (state_d == ST_WAIT);
      if (launch) begin
        dmem_we_o    <= MemWrite_i;
        dmem_addr_o  <= {ALUResult_i[31:2], 2'b00};
        dmem_wdata_o <= RS2data_i;
      end
      if (state_q == ST_WAIT && state_d == ST_WAIT) cnt_q <= cnt_q + CNT_W'(1);
      else                                          cnt_q <= '0;
      if (wb_sel == WB_ABORT) err_o <= 1'b1;
    end
  end

  // MEM/WB boundary register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      RegWrite_o  <= 1'b0;
      MemtoReg_o  <= 1'b0;
      ReadData_o  <= '0;
      ALUResult_o <= '0;
      RDaddr_o    <= '0;
    end else begin
      case (wb_sel)
        WB_PASS: begin
          RegWrite_o  <= RegWrite_i;
          MemtoReg_o  <= MemtoReg_i;
          ReadData_o  <= '0;
          ALUResult_o <= ALUResult_i;
          RDaddr_o    <= RDaddr_i;
        end
        WB_DONE: begin
          RegWrite_o  <= RegWrite_i;
          MemtoReg_o  <= MemtoReg_i;
          ReadData_o  <= dmem_we_o ? 32'd0 : dmem_rdata_i;
          ALUResult_o <= ALUResult_i;
          RDaddr_o    <= RDaddr_i;
        end
        WB_ABORT: begin
          // The instruction retires, but it must not write a register with missing data
          RegWrite_o  <= 1'b0;
          MemtoReg_o  <= MemtoReg_i;
          ReadData_o  <= '0;
          ALUResult_o <= ALUResult_i;
          RDaddr_o    <= RDaddr_i;
        end
        default: begin
          RegWrite_o  <= 1'b0;
          MemtoReg_o  <= 1'b0;
          ReadData_o  <= '0;
          ALUResult_o <= '0;
          RDaddr_o    <= '0;
        end
      endcase
    end
  end

endmodule
